// File: rtl/fnd_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fnd_scan_controller                                          |
// | Description : Time-multiplexed scan driver for a 4-digit FND. Steps a      |
// |               digit pointer at a programmable rate and presents the digit  |
// |               index with its nibble. New display values are double-       |
// |               buffered and only take effect at frame boundaries.           |
// |                                                                            |
// | Parameters  : CLK_DIV        clk cycles per digit slot (>= 1)              |
// |                                                                            |
// | Ports       : i_clk          system clock, rising edge                     |
// |               i_reset        synchronous, active-high reset                |
// |               i_enable       scan enable; low freezes scan, blanks display |
// |               i_load         strobe: capture i_bcd into the shadow word    |
// |               i_bcd[15:0]    display value, [3:0] = digit 0 (rightmost)    |
// |               o_digitSelect  current digit index -> select decoder         |
// |               o_value[3:0]   nibble of current digit -> segment decoder    |
// |               o_en           display enable -> both decoders               |
// |               o_frameDone    one-cycle pulse after the 3 -> 0 wrap         |
// |                                                                            |
// | Build macro : FND_LZ_BLANK_EN  when defined, leading-zero digits are       |
// |                                blanked by forcing o_en low in their slot   |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fnd_scan_controller #(
    parameter int CLK_DIV = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_load,
    input  logic [15:0] i_bcd,
    output logic [1:0]  o_digitSelect,
    output logic [3:0]  o_value,
    output logic        o_en,
    output logic        o_frameDone
);

    localparam int                c_PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLK_DIV - 1);

    logic [c_PRE_W-1:0] r_prescaler;
    logic [1:0]         r_digit;
    logic [15:0]        r_active;
    logic [15:0]        r_shadow;
    logic               r_pending;
    logic               r_en;
    logic               r_frame_done;

    logic               w_tick;
    logic               w_wrap;

    assign w_tick = i_enable && (r_prescaler == c_PRE_LAST);
    assign w_wrap = w_tick && (r_digit == 2'd3);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prescaler  <= '0;
            r_digit      <= 2'd0;
            r_active     <= 16'h0000;
            r_shadow     <= 16'h0000;
            r_pending    <= 1'b0;
            r_en         <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_en         <= i_enable;
            r_frame_done <= w_wrap;

            if (i_enable) begin
                r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
            end
            if (w_tick) begin
                r_digit <= r_digit + 2'd1;
            end

            // A load coinciding with the wrap bypasses the shadow so the new
            // value is shown from digit 0 of the frame that starts now.
            if (w_wrap && i_load) begin
                r_active  <= i_bcd;
                r_shadow  <= i_bcd;
                r_pending <= 1'b0;
            end else if (i_load) begin
                r_shadow  <= i_bcd;
                r_pending <= 1'b1;
            end else if (w_wrap && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    // Zero-latency mux keeps the nibble aligned with the digit index.
    assign o_value       = r_active[{r_digit, 2'b00} +: 4];
    assign o_digitSelect = r_digit;
    assign o_frameDone   = r_frame_done;

`ifdef FND_LZ_BLANK_EN
    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 is
    // never blanked so a zero value still shows a single "0".
    logic w_blank;

    always_comb begin
        w_blank = 1'b0;
        case (r_digit)
            2'd3:    w_blank = (r_active[15:12] == 4'h0);
            2'd2:    w_blank = (r_active[15:8]  == 8'h00);
            2'd1:    w_blank = (r_active[15:4]  == 12'h000);
            default: w_blank = 1'b0;
        endcase
    end

    assign o_en = r_en && !w_blank;
`else
    assign o_en = r_en;
`endif

endmodule
`default_nettype wire
